// File: rtl/reaction_pkg.sv
// Shared types and default timing constants for the reaction-time game controller.
package reaction_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_DELAY,
      RUN,
      HOLD,
      FAULT
   } state_t;

   localparam int unsigned MIN_DELAY_MS_DEFAULT = 1000;
   localparam int unsigned TIMEOUT_MS_DEFAULT   = 9999;

endpackage

// File: rtl/delay_timer.sv
// Millisecond down-counter for the pre-stimulus random wait.
// expired flags the tick that consumes the final millisecond (count found at 1).
module delay_timer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [12:0] load_val,
   input  logic        tick,
   output logic        expired
);

   logic [12:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= load_val;
      end else if (tick && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 13'd1;
      end
   end

   assign expired = tick && (r_cnt == 13'd1);

endmodule

// File: rtl/reaction_controller.sv
// Reaction-time game sequencer: random wait, stimulus lamp, external counter control
// and registered result/false-start/timeout flags.
module reaction_controller
   import reaction_pkg::*;
#(
   parameter int unsigned MIN_DELAY_MS = MIN_DELAY_MS_DEFAULT,
   parameter int unsigned TIMEOUT_MS   = TIMEOUT_MS_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tick_ms,
   input  logic        start_btn,
   input  logic        react_btn,
   input  logic [11:0] rand_delay,
   input  logic [15:0] count_in,
   output logic        start_counting,
   output logic        end_counting,
   output logic        lights_on,
   output logic        result_valid,
   output logic        false_start,
   output logic        timeout,
   output logic        busy
);

   localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_MS);
   localparam logic [12:0] MIN_VAL     = 13'(MIN_DELAY_MS);

   state_t      r_state, w_state_nxt;
   logic        r_start_cnt, r_end_cnt, r_lights, r_valid, r_fs, r_to, r_busy;
   logic        w_start_cnt_nxt, w_end_cnt_nxt, w_lights_nxt, w_valid_nxt, w_fs_nxt, w_to_nxt;
   logic        w_load, w_tick, w_expired;
   logic [12:0] w_load_val;

   assign w_load_val = MIN_VAL + {1'b0, rand_delay};
   // A same-cycle react_btn wins, so its tick must not reach the timer either.
   assign w_tick = tick_ms && (r_state == WAIT_DELAY) && !react_btn;

   delay_timer u_delay_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (w_load),
      .load_val (w_load_val),
      .tick     (w_tick),
      .expired  (w_expired)
   );

   always_comb begin
      w_state_nxt     = r_state;
      w_start_cnt_nxt = 1'b0;
      w_end_cnt_nxt   = 1'b0;
      w_lights_nxt    = r_lights;
      w_valid_nxt     = r_valid;
      w_fs_nxt        = r_fs;
      w_to_nxt        = r_to;
      w_load          = 1'b0;
      case (r_state)
         IDLE, HOLD, FAULT: begin
            if (start_btn) begin
               w_load      = 1'b1;
               w_valid_nxt = 1'b0;
               w_fs_nxt    = 1'b0;
               w_to_nxt    = 1'b0;
               w_state_nxt = WAIT_DELAY;
            end
         end
         WAIT_DELAY: begin
            if (react_btn) begin
               w_fs_nxt    = 1'b1;
               w_state_nxt = FAULT;
            end else if (w_expired) begin
               w_lights_nxt    = 1'b1;
               w_start_cnt_nxt = 1'b1;
               w_state_nxt     = RUN;
            end
         end
         RUN: begin
            if (react_btn) begin
               w_end_cnt_nxt = 1'b1;
               w_lights_nxt  = 1'b0;
               w_valid_nxt   = 1'b1;
               w_state_nxt   = HOLD;
            end else if (count_in >= TIMEOUT_VAL) begin
               w_end_cnt_nxt = 1'b1;
               w_lights_nxt  = 1'b0;
               w_to_nxt      = 1'b1;
               w_state_nxt   = HOLD;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_start_cnt <= 1'b0;
         r_end_cnt   <= 1'b0;
         r_lights    <= 1'b0;
         r_valid     <= 1'b0;
         r_fs        <= 1'b0;
         r_to        <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_start_cnt <= w_start_cnt_nxt;
         r_end_cnt   <= w_end_cnt_nxt;
         r_lights    <= w_lights_nxt;
         r_valid     <= w_valid_nxt;
         r_fs        <= w_fs_nxt;
         r_to        <= w_to_nxt;
         r_busy      <= (w_state_nxt == WAIT_DELAY) || (w_state_nxt == RUN);
      end
   end

   assign start_counting = r_start_cnt;
   assign end_counting   = r_end_cnt;
   assign lights_on      = r_lights;
   assign result_valid   = r_valid;
   assign false_start    = r_fs;
   assign timeout        = r_to;
   assign busy           = r_busy;

endmodule

// File: doc/reaction_controller.md
REACTION_CONTROLLER -- requirements
Module: reaction_controller

Interface
REQ-001 Parameter: MIN_DELAY_MS, default 1000, minimum random wait before the lights go on, in ms.
REQ-002 Parameter: TIMEOUT_MS, default 9999, count value at which a run is abandoned.
REQ-003 Port: clk  in  1  system clock; the only clock.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: tick_ms  in  1  one-cycle enable, once per ms.
REQ-006 Port: start_btn  in  1  synchronised, debounced one-cycle pulse; starts a round.
REQ-007 Port: react_btn  in  1  synchronised, debounced one-cycle pulse; player response.
REQ-008 Port: rand_delay  in  12  random ms offset, sampled only on an accepted start.
REQ-009 Port: count_in  in  16  live value from the reaction counter.
REQ-010 Port: start_counting  out  1  one-cycle pulse to the reaction counter.
REQ-011 Port: end_counting  out  1  one-cycle pulse to the reaction counter.
REQ-012 Port: lights_on  out  1  stimulus lamp.
REQ-013 Port: result_valid  out  1  count_in holds a valid reaction time.
REQ-014 Port: false_start  out  1  player reacted before the lights went on.
REQ-015 Port: timeout  out  1  no reaction before TIMEOUT_MS.
REQ-016 Port: busy  out  1  high in WAIT_DELAY and RUN.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT_DELAY, RUN, HOLD and FAULT.
REQ-018 All outputs SHALL be registered.
REQ-019 In IDLE, HOLD or FAULT, start_btn SHALL:
- load delay_cnt = MIN_DELAY_MS + rand_delay (13-bit, no overflow; max 5095);
- clear result_valid, false_start and timeout;
- enter WAIT_DELAY.
REQ-020 In WAIT_DELAY, react_btn SHALL enter FAULT with false_start=1 and no counter pulse; react_btn takes priority over a same-cycle tick_ms.
REQ-021 In WAIT_DELAY, each tick_ms SHALL decrement delay_cnt; the tick that finds delay_cnt==1 SHALL enter RUN, set lights_on=1 and pulse start_counting for exactly one cycle.
REQ-022 In RUN, react_btn SHALL pulse end_counting for one cycle, clear lights_on, set result_valid=1 and enter HOLD.
REQ-023 In RUN without react_btn, count_in >= TIMEOUT_MS SHALL pulse end_counting, clear lights_on, set timeout=1 and enter HOLD.
REQ-024 If react_btn and the timeout condition occur in the same cycle, react_btn SHALL win: result_valid=1, timeout=0.
REQ-025 start_btn SHALL be ignored in WAIT_DELAY and RUN; react_btn SHALL be ignored in IDLE, HOLD and FAULT.
REQ-026 start_counting and end_counting SHALL never be high in the same cycle and SHALL each be high for at most one cycle per round.
REQ-027 result_valid, false_start and timeout SHALL be mutually exclusive and SHALL hold until the next accepted start or reset.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, delay_cnt=0 and all outputs 0, including mid-WAIT_DELAY and mid-RUN.
REQ-029 After rst_n deasserts, the first accepted start_btn SHALL behave exactly as in REQ-019.

Structure
REQ-030 The state enumeration, MIN_DELAY_MS and TIMEOUT_MS defaults SHALL live in shared package reaction_pkg.
REQ-031 The ms down-counter SHALL be a sub-module, delay_timer, with ports load, load_val[12:0], tick, expired.
REQ-032 The 16-bit reaction counter SHALL remain external; this block only drives start_counting and end_counting and reads count_in.

Verification
REQ-033 Normal round: start_btn with rand_delay=0 -> start_counting on the 1000th tick_ms; react_btn at count_in=250 -> one end_counting pulse, result_valid=1, lights_on=0.
REQ-034 False start: react_btn at tick 500 of WAIT_DELAY -> false_start=1, FAULT, no start_counting or end_counting pulse ever.
REQ-035 Timeout: no react_btn, count_in driven to 9999 -> end_counting pulse, timeout=1, result_valid=0.
REQ-036 Race: react_btn in the same cycle count_in reaches 9999 -> result_valid=1, timeout=0, single end_counting pulse.
REQ-037 Reset mid-run: rst_n low during RUN -> all outputs 0 asynchronously; start_btn after release with rand_delay=4095 -> start_counting on tick 5095.
REQ-038 Ignore rules: start_btn during RUN and react_btn during HOLD -> no state or flag change.
